control_pipeline: RTL
=====================

CONTROL_PIPELINE -- requirements
Module: control_pipeline

Interface
REQ-001 SHALL have parameter STAGES, default 3, number of control register stages after decode (EX, MEM, WB); legal 1..8.
REQ-002 SHALL have parameter SUPPORT_JUMP, default 1, enables JAL/JALR/LUI/AUIPC decode.
REQ-003 SHALL have port clk_i  input  1  sole clock, rising edge.
REQ-004 SHALL have port rst_i  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port valid_i  input  1  instr_i holds a valid instruction.
REQ-006 SHALL have port instr_i  input  32  instruction in decode.
REQ-007 SHALL have port stall_i  input  1  freeze all stages.
REQ-008 SHALL have port flush_i  input  1  kill the decode-stage instruction.
REQ-009 SHALL have port ctrl_o  output  STAGES x ctrl_pipe_t  registered control per stage; index 0 = EX.
REQ-010 SHALL have port valid_o  output  STAGES  per-stage valid.
REQ-011 SHALL have port is_branch_o  output  1  decode-stage SB-type, combinational.
REQ-012 SHALL have port is_jump_o  output  1  decode-stage JAL/JALR, combinational.
REQ-013 SHALL have port load_use_stall_o  output  1  load-use hazard; upstream holds instr_i.
REQ-014 SHALL have port illegal_o  output  1  decode-stage unsupported opcode, combinational.

Function
REQ-015 SHALL decode on instr_i[6:2], requiring instr_i[1:0]=11, else illegal.
REQ-016 SHALL decode R (01100): reg_dst 1, reg_write 1, alu_op 10, alu_src 0, mem_to_reg 1.
REQ-017 SHALL decode I-ALU (00100): reg_write 1, alu_op 10, alu_src 1, mem_to_reg 1.
REQ-018 SHALL decode load (00000): reg_write 1, alu_op 00, alu_src 1, mem_read 1, mem_to_reg 0.
REQ-019 SHALL decode store (01000): alu_op 00, alu_src 1, mem_write from funct3: 000->0001, 001->0011, 010->1111, other->illegal.
REQ-020 SHALL decode branch (11000): alu_op 01, branch 1, reg_write 0.
REQ-021 SHALL, when SUPPORT_JUMP=1, decode JAL (11011) and JALR (11001) with jump 1 and reg_write 1, and LUI (01101) and AUIPC (00101) with reg_write 1 and alu_src 1; when SUPPORT_JUMP=0 these SHALL be illegal.
REQ-022 SHALL set every field of an illegal instruction or bubble to zero.
REQ-023 SHALL capture rd=instr_i[11:7] and force reg_write 0 when rd=0.
REQ-024 SHALL gate is_branch_o, is_jump_o and illegal_o with valid_i.
REQ-025 SHALL assert load_use_stall_o combinationally when valid_i, valid_o[0], ctrl_o[0].mem_read, ctrl_o[0].rd!=0, and rd equals instr_i rs1 [19:15] or rs2 [24:20].
REQ-026 SHALL advance every stage per clock (decode->0, k-1->k) with one-cycle latency per stage.
REQ-027 SHALL, while stall_i=1 and flush_i=0, hold all stages unchanged.
REQ-028 SHALL, on flush_i=1 or load_use_stall_o=1 or illegal, load a bubble (valid 0, all-zero) into stage 0.
REQ-029 SHALL, on flush_i=1 with stall_i=1, load the bubble into stage 0 while stages 1..STAGES-1 hold.
REQ-030 SHALL, on load_use_stall_o=1 with stall_i=0, advance stages 1..STAGES-1 normally.

Reset
REQ-031 SHALL, on rst_i=1 at a clock edge, clear all valid_o and all ctrl_o fields to zero, overriding stall_i and flush_i.
REQ-032 SHALL hold load_use_stall_o at 0 in the first cycle after reset, because stage 0 is then invalid.

Structure
REQ-033 SHALL take ctrl_pipe_t (reg_dst, reg_write, alu_op[1:0], alu_src, mem_write[3:0], mem_read, mem_to_reg, branch, jump, rd[4:0]), opcode constants and ALU_OP constants from cpu_pkg.
REQ-034 SHALL implement decode as one combinational sub-module control_decode, instantiated once.

Verification
REQ-035 SHALL cover reset: rst_i=1 for 2 cycles mid-stream -> valid_o=000, all ctrl_o zero.
REQ-036 SHALL cover pipeline advance: 0x002081B3 (add x3,x1,x2) -> stage0 reg_write=1, alu_op=10, rd=3 at +1; stage1 at +2; stage2 at +3.
REQ-037 SHALL cover load-use: 0x0000A283 then 0x00128333 -> load_use_stall_o=1 one cycle, stage0 bubble, add enters stage0 next cycle.
REQ-038 SHALL cover store width: 0x00209223 (sh) -> mem_write=0011, reg_write=0, alu_src=1.
REQ-039 SHALL cover stall and flush: stall_i 3 cycles -> ctrl_o unchanged; stall_i with flush_i -> valid_o[0]=0, stages 1..2 held.
REQ-040 SHALL cover illegal opcode: 0x000000EF with SUPPORT_JUMP=0 -> illegal_o=1, bubble; with SUPPORT_JUMP=1 -> is_jump_o=1, rd=1.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared decode types and encodings for the control pipeline.
// Opcodes are instr[6:2] (the two low bits must read 11).
package cpu_pkg;

  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_IMM    = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OP     = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;

  localparam logic [1:0] ALU_OP_ADD    = 2'b00;
  localparam logic [1:0] ALU_OP_BRANCH = 2'b01;
  localparam logic [1:0] ALU_OP_FUNCT  = 2'b10;

  typedef struct packed {
    logic       reg_dst;
    logic       reg_write;
    logic [1:0] alu_op;
    logic       alu_src;
    logic [3:0] mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       branch;
    logic       jump;
    logic [4:0] rd;
  } ctrl_pipe_t;

  localparam ctrl_pipe_t CTRL_BUBBLE = '0;

  // Returns {legal, byte_strobe} for a store funct3.
  function automatic logic [4:0] store_strobe(input logic [2:0] funct3);
    case (funct3)
      3'b000:  store_strobe = 5'b1_0001;
      3'b001:  store_strobe = 5'b1_0011;
      3'b010:  store_strobe = 5'b1_1111;
      default: store_strobe = 5'b0_0000;
    endcase
  endfunction

endpackage

// File: rtl/control_pipeline_if.sv
// Decode-stage bundle: instruction in, decoded control and flags out.
interface control_pipeline_if;
  import cpu_pkg::*;

  logic       valid;
  logic [31:0] instr;
  ctrl_pipe_t ctrl;
  logic       illegal;
  logic       is_branch;
  logic       is_jump;

  modport master (
    output valid, instr,
    input  ctrl, illegal, is_branch, is_jump
  );

  modport slave (
    input  valid, instr,
    output ctrl, illegal, is_branch, is_jump
  );

endinterface

// File: rtl/control_decode.sv
// Combinational instruction decoder; every output is zero unless a valid,
// legal instruction is presented.
module control_decode
  import cpu_pkg::*;
#(
  parameter bit SUPPORT_JUMP = 1'b1
) (
  control_pipeline_if.slave dec
);

  ctrl_pipe_t c;
  logic       ill;
  logic       br;
  logic       jp;
  logic [4:0] st;

  always_comb begin
    c   = CTRL_BUBBLE;
    ill = 1'b0;
    br  = 1'b0;
    jp  = 1'b0;
    st  = store_strobe(dec.instr[14:12]);
    if (dec.instr[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (dec.instr[6:2])
        OP_OP: begin
          c.reg_dst    = 1'b1;
          c.reg_write  = 1'b1;
          c.alu_op     = ALU_OP_FUNCT;
          c.mem_to_reg = 1'b1;
        end
        OP_IMM: begin
          c.reg_write  = 1'b1;
          c.alu_op     = ALU_OP_FUNCT;
          c.alu_src    = 1'b1;
          c.mem_to_reg = 1'b1;
        end
        OP_LOAD: begin
          c.reg_write = 1'b1;
          c.alu_op    = ALU_OP_ADD;
          c.alu_src   = 1'b1;
          c.mem_read  = 1'b1;
        end
        OP_STORE: begin
          c.alu_op    = ALU_OP_ADD;
          c.alu_src   = 1'b1;
          c.mem_write = st[3:0];
          ill         = ~st[4];
        end
        OP_BRANCH: begin
          c.alu_op = ALU_OP_BRANCH;
          c.branch = 1'b1;
          br       = 1'b1;
        end
        OP_JAL, OP_JALR: begin
          if (SUPPORT_JUMP) begin
            c.jump      = 1'b1;
            c.reg_write = 1'b1;
            jp          = 1'b1;
          end else begin
            ill = 1'b1;
          end
        end
        OP_LUI, OP_AUIPC: begin
          if (SUPPORT_JUMP) begin
            c.reg_write = 1'b1;
            c.alu_src   = 1'b1;
          end else begin
            ill = 1'b1;
          end
        end
        default: ill = 1'b1;
      endcase
    end

    if (ill) begin
      c  = CTRL_BUBBLE;
      br = 1'b0;
      jp = 1'b0;
    end else begin
      c.rd = dec.instr[11:7];
      // x0 is hardwired: never let a write to it travel down the pipe
      if (c.rd == 5'd0) c.reg_write = 1'b0;
    end

    if (!dec.valid) begin
      c   = CTRL_BUBBLE;
      ill = 1'b0;
      br  = 1'b0;
      jp  = 1'b0;
    end
  end

  assign dec.ctrl      = c;
  assign dec.illegal   = ill;
  assign dec.is_branch = br;
  assign dec.is_jump   = jp;

endmodule

// File: rtl/control_pipeline.sv
// Decode followed by STAGES registered control stages (index 0 = EX), with
// stall, flush and load-use bubble insertion.
module control_pipeline
  import cpu_pkg::*;
#(
  parameter int unsigned STAGES       = 3,
  parameter bit          SUPPORT_JUMP = 1'b1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    valid_i,
  input  logic [31:0]             instr_i,
  input  logic                    stall_i,
  input  logic                    flush_i,
  output ctrl_pipe_t [STAGES-1:0] ctrl_o,
  output logic [STAGES-1:0]       valid_o,
  output logic                    is_branch_o,
  output logic                    is_jump_o,
  output logic                    load_use_stall_o,
  output logic                    illegal_o
);

  control_pipeline_if dec_bus ();

  assign dec_bus.valid = valid_i;
  assign dec_bus.instr = instr_i;

  control_decode #(
    .SUPPORT_JUMP(SUPPORT_JUMP)
  ) u_decode (
    .dec(dec_bus)
  );

  ctrl_pipe_t [STAGES-1:0] ctrl_reg;
  ctrl_pipe_t [STAGES-1:0] ctrl_next;
  logic [STAGES-1:0]       valid_reg;
  logic [STAGES-1:0]       valid_next;
  ctrl_pipe_t              ctrl0_next;
  logic                    valid0_next;
  logic                    load_use;

  // A load in EX whose destination feeds the decode instruction must be
  // separated from it by one bubble; upstream holds instr_i meanwhile.
  assign load_use = valid_i && valid_reg[0] && ctrl_reg[0].mem_read &&
                    (ctrl_reg[0].rd != 5'd0) &&
                    ((ctrl_reg[0].rd == instr_i[19:15]) ||
                     (ctrl_reg[0].rd == instr_i[24:20]));

  always_comb begin
    ctrl0_next  = ctrl_reg[0];
    valid0_next = valid_reg[0];
    if (flush_i) begin
      ctrl0_next  = CTRL_BUBBLE;
      valid0_next = 1'b0;
    end else if (!stall_i) begin
      if (load_use || dec_bus.illegal || !valid_i) begin
        ctrl0_next  = CTRL_BUBBLE;
        valid0_next = 1'b0;
      end else begin
        ctrl0_next  = dec_bus.ctrl;
        valid0_next = 1'b1;
      end
    end
  end

  assign ctrl_next[0]  = ctrl0_next;
  assign valid_next[0] = valid0_next;

  // Later stages only look at stall; flush and load-use affect stage 0 alone.
  generate
    for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
      assign ctrl_next[gi]  = stall_i ? ctrl_reg[gi]  : ctrl_reg[gi-1];
      assign valid_next[gi] = stall_i ? valid_reg[gi] : valid_reg[gi-1];
    end
  endgenerate

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ctrl_reg  <= '0;
      valid_reg <= '0;
    end else begin
      ctrl_reg  <= ctrl_next;
      valid_reg <= valid_next;
    end
  end

  assign ctrl_o           = ctrl_reg;
  assign valid_o          = valid_reg;
  assign is_branch_o      = dec_bus.is_branch;
  assign is_jump_o        = dec_bus.is_jump;
  assign illegal_o        = dec_bus.illegal;
  assign load_use_stall_o = load_use;

endmodule
